// File: rtl/dcache_coherence_agent.sv
// dcache_coherence_agent: per-core MSI agent issuing fills, writebacks and upgrades and answering bus snoops.
module dcache_coherence_agent (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] wb_data0,
  input  logic [31:0] wb_data1,
  output logic        req_done,
  output logic [31:0] fill_data0,
  output logic [31:0] fill_data1,
  output logic        dREN,
  output logic        dWEN,
  output logic        ccwrite,
  output logic        cctrans,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] dload,
  input  logic [31:0] ccsnoopaddr,
  output logic [31:0] snp_addr,
  input  logic        snp_hit,
  input  logic [1:0]  snp_state,
  input  logic [31:0] snp_data0,
  input  logic [31:0] snp_data1,
  output logic        snp_set,
  output logic [1:0]  snp_newstate
);
  localparam logic [3:0] IDLE = 4'd0, FILL0 = 4'd1, FILL1 = 4'd2, WB0 = 4'd3, WB1 = 4'd4,
                         UPG = 4'd5, DONE = 4'd6, SNP_CHK = 4'd7, SNP_WB0 = 4'd8, SNP_WB1 = 4'd9;
  logic [3:0]  state, nstate;
  logic [31:0] blk, snp_blk, sd0, sd1;
  logic [1:0]  kind;
  logic        pend, set_q, snp_m, accept, yield;
  function automatic logic [3:0] first(input logic [1:0] k);
    return k == 2'd0 ? FILL0 : k == 2'd1 ? WB0 : UPG;
  endfunction
  assign snp_addr     = ccsnoopaddr & ~32'd7;
  assign snp_m        = snp_hit && snp_state == 2'd2;
  assign snp_newstate = 2'd0;
  assign accept       = state == IDLE && !ccwait && !pend && req_valid && req_type != 2'd3;
  assign yield        = (state == FILL0 || state == WB0 || state == UPG) && dwait && ccwait;
  assign req_done     = state == DONE;
  assign dREN         = state == FILL0 || state == FILL1;
  assign dWEN         = state == WB0 || state == WB1;
  assign ccwrite      = state == UPG;
  assign cctrans      = state == SNP_WB0 || state == SNP_WB1 || (state == SNP_CHK && snp_m);
  assign daddr  = (state == FILL0 || state == WB0 || state == UPG) ? blk :
                  (state == FILL1 || state == WB1) ? blk | 32'd4 :
                  state == SNP_CHK ? snp_addr :
                  state == SNP_WB0 ? snp_blk :
                  state == SNP_WB1 ? snp_blk | 32'd4 : '0;
  assign dstore = state == WB0 ? wb_data0 : state == WB1 ? wb_data1 :
                  state == SNP_WB0 ? sd0 : state == SNP_WB1 ? sd1 : '0;
  // set_q spaces invalidations so the tag lookup is re-evaluated after each write
  assign snp_set = (state == SNP_WB1 && !dwait) ||
                   (state == SNP_CHK && !snp_m && ccinv && snp_hit && !set_q);
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = ccwait ? SNP_CHK : pend ? first(kind) : accept ? first(req_type) : IDLE;
      FILL0:   nstate = !dwait ? FILL1 : ccwait ? SNP_CHK : FILL0;
      FILL1:   nstate = !dwait ? DONE : FILL1;
      WB0:     nstate = !dwait ? WB1 : ccwait ? SNP_CHK : WB0;
      WB1:     nstate = !dwait ? DONE : WB1;
      UPG:     nstate = !dwait ? DONE : ccwait ? SNP_CHK : UPG;
      DONE:    nstate = IDLE;
      SNP_CHK: nstate = snp_m ? SNP_WB0 : (ccinv && snp_hit) ? SNP_CHK : !ccwait ? IDLE : SNP_CHK;
      SNP_WB0: nstate = !dwait ? SNP_WB1 : SNP_WB0;
      SNP_WB1: nstate = !dwait ? SNP_CHK : SNP_WB1;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      blk        <= '0;
      kind       <= '0;
      pend       <= 1'b0;
      set_q      <= 1'b0;
      snp_blk    <= '0;
      sd0        <= '0;
      sd1        <= '0;
      fill_data0 <= '0;
      fill_data1 <= '0;
    end else begin
      state <= nstate;
      set_q <= snp_set;
      pend  <= yield ? 1'b1 : (state == IDLE && !ccwait) ? 1'b0 : pend;
      if (accept) begin
        blk  <= req_addr & ~32'd7;
        kind <= req_type;
      end
      if (state == FILL0 && !dwait) fill_data0 <= dload;
      if (state == FILL1 && !dwait) fill_data1 <= dload;
      if (state == SNP_CHK && snp_m) begin
        snp_blk <= snp_addr;
        sd0     <= snp_data0;
        sd1     <= snp_data1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_coherence_agent.sv
// tb_dcache_coherence_agent: scoreboard bench with a wait-state bus model and a small tag-array model.
module tb_dcache_coherence_agent;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = '0;
  logic [31:0] req_addr = '0, wb_data0 = '0, wb_data1 = '0;
  logic        req_done, dREN, dWEN, ccwrite, cctrans, snp_set;
  logic [31:0] fill_data0, fill_data1, daddr, dstore, dload, snp_addr;
  logic        dwait, ccwait = 1'b0, ccinv = 1'b0;
  logic [31:0] ccsnoopaddr = '0;
  logic        snp_hit;
  logic [1:0]  snp_state, snp_newstate;
  logic [31:0] snp_data0, snp_data1;

  dcache_coherence_agent dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .req_done(req_done), .fill_data0(fill_data0),
    .fill_data1(fill_data1), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
    .daddr(daddr), .dstore(dstore), .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv), .dload(dload),
    .ccsnoopaddr(ccsnoopaddr), .snp_addr(snp_addr), .snp_hit(snp_hit), .snp_state(snp_state),
    .snp_data0(snp_data0), .snp_data1(snp_data1), .snp_set(snp_set), .snp_newstate(snp_newstate)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  typ;
    logic [3:0]  stb;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0;
  int wait_n = 2;
  int ct_cnt = 0;

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a == 32'h100 ? 32'hAAAA : a == 32'h104 ? 32'hBBBB : a ^ 32'h5A5A0000;
  endfunction
  assign dload = mem_rd(daddr);

  // bus model: dwait drops after wait_n cycles of an unchanged request
  initial begin
    logic [97:0] key, pkey;
    logic act;
    int cnt;
    dwait = 1'b1;
    pkey = '0;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #2;
      key = {dREN, dWEN, ccwrite, cctrans, daddr, dstore};
      act = dREN | dWEN | ccwrite | cctrans;
      cnt = (!act || key != pkey || !dwait) ? 0 : cnt + 1;
      pkey = key;
      dwait = !(act && cnt >= wait_n);
    end
  end

  // tag model: lines 0x400 (M), 0x500/0x600/0x700 (S); snp_set invalidates the looked-up line
  logic [1:0] t_st[4];
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      t_st[0] <= 2'd2;
      t_st[1] <= 2'd1;
      t_st[2] <= 2'd1;
      t_st[3] <= 2'd1;
    end else if (snp_set)
      for (int i = 0; i < 4; i++)
        if (32'h400 + 32'(i) * 32'h100 == snp_addr) t_st[i] <= snp_newstate;
  end
  always_comb begin
    snp_hit = 1'b0;
    snp_state = 2'd0;
    snp_data0 = '0;
    snp_data1 = '0;
    for (int i = 0; i < 4; i++)
      if (t_st[i] != 2'd0 && 32'h400 + 32'(i) * 32'h100 == snp_addr) begin
        snp_hit = 1'b1;
        snp_state = t_st[i];
        snp_data0 = 32'hC0 | (32'(i) << 8);
        snp_data1 = 32'hC1 | (32'(i) << 8);
      end
  end

  task automatic post(input string name, input ev_t ev);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s: got %h expected none", name, ev);
    end else chk(name, ev, exp_q.pop_front());
  endtask

  always @(negedge CLK) begin
    if (cctrans) ct_cnt++;
    if (nRST) begin
      if ((dREN | dWEN | ccwrite | cctrans) && !dwait) post("bus", {2'd0, dREN, dWEN, ccwrite, cctrans, daddr, dstore});
      if (req_done) post("done", {2'd1, 4'd0, fill_data0, fill_data1});
      if (snp_set) post("snp_set", {2'd2, 4'd0, 30'd0, snp_newstate, 32'd0});
    end
  end

  function automatic ev_t bus(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    return {2'd0, s, a, d};
  endfunction
  function automatic ev_t done(input logic [31:0] a, input logic [31:0] b);
    return {2'd1, 4'd0, a, b};
  endfunction
  localparam ev_t SET_I = {2'd2, 4'd0, 64'd0};

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!req_done && cyc < 300) begin
      tick(1);
      cyc++;
    end
    chk("req_done_seen", {69'd0, req_done}, 70'd1);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] w0,
                        input logic [31:0] w1, output int cyc);
    tick(1);
    req_valid = 1'b1;
    req_type = t;
    req_addr = a;
    wb_data0 = w0;
    wb_data1 = w1;
    wait_done(cyc);
  endtask

  initial begin
    int cyc, ct0;
    #12;
    chk("reset_outs", {dREN, dWEN, ccwrite, cctrans, req_done, snp_set, snp_newstate, daddr, dstore}, '0);
    chk("reset_fill", {6'd0, fill_data0, fill_data1}, '0);
    #10 nRST = 1'b1;
    // FILL with two wait cycles per word
    wait_n = 2;
    exp_q.push_back(bus(4'b1000, 32'h100, 0));
    exp_q.push_back(bus(4'b1000, 32'h104, 0));
    exp_q.push_back(done(32'hAAAA, 32'hBBBB));
    do_req(2'd0, 32'h100, 0, 0, cyc);
    chk("fill_latency", 70'(cyc), 70'd7);
    // WB: fill registers keep the last fill
    wait_n = 1;
    exp_q.push_back(bus(4'b0100, 32'h200, 32'h11));
    exp_q.push_back(bus(4'b0100, 32'h204, 32'h22));
    exp_q.push_back(done(32'hAAAA, 32'hBBBB));
    do_req(2'd1, 32'h203, 32'h11, 32'h22, cyc);
    chk("wb_latency", 70'(cyc), 70'd5);
    // UPG with immediate grant: minimum two cycles
    wait_n = 0;
    exp_q.push_back(bus(4'b0010, 32'h300, 0));
    exp_q.push_back(done(32'hAAAA, 32'hBBBB));
    do_req(2'd2, 32'h300, 0, 0, cyc);
    chk("upg_latency", 70'(cyc), 70'd2);
    // snoop hits M line: two cctrans writeback beats, then invalidate
    wait_n = 2;
    tick(1);
    ct0 = ct_cnt;
    ccsnoopaddr = 32'h404;
    ccwait = 1'b1;
    ccinv = 1'b1;
    exp_q.push_back(bus(4'b0001, 32'h400, 32'hC0));
    exp_q.push_back(bus(4'b0001, 32'h404, 32'hC1));
    exp_q.push_back(SET_I);
    tick(12);
    ccwait = 1'b0;
    ccinv = 1'b0;
    tick(3);
    chk("snoop_m_cctrans_cycles", 70'(ct_cnt - ct0), 70'd7);
    // snoop hits S line with ccinv: invalidate only
    ct0 = ct_cnt;
    ccsnoopaddr = 32'h500;
    ccwait = 1'b1;
    ccinv = 1'b1;
    exp_q.push_back(SET_I);
    tick(5);
    ccwait = 1'b0;
    ccinv = 1'b0;
    tick(3);
    chk("snoop_s_inv_no_cctrans", 70'(ct_cnt - ct0), 70'd0);
    // snoop hits S line without ccinv: nothing happens
    ct0 = ct_cnt;
    ccsnoopaddr = 32'h600;
    ccwait = 1'b1;
    tick(5);
    chk("snoop_s_line_kept", {67'd0, snp_hit, snp_state}, {67'd0, 1'b1, 2'd1});
    ccwait = 1'b0;
    tick(3);
    chk("snoop_s_noinv_no_cctrans", 70'(ct_cnt - ct0), 70'd0);
    // FILL yields to a snoop while stalled in FILL0, then restarts from word 0
    wait_n = 100;
    req_valid = 1'b1;
    req_type = 2'd0;
    req_addr = 32'h187;
    tick(2);
    chk("yield_dren_before", {69'd0, dREN}, 70'd1);
    ccsnoopaddr = 32'h700;
    ccwait = 1'b1;
    ccinv = 1'b1;
    exp_q.push_back(SET_I);
    exp_q.push_back(bus(4'b1000, 32'h180, 0));
    exp_q.push_back(bus(4'b1000, 32'h184, 0));
    exp_q.push_back(done(32'h5A5A0180, 32'h5A5A0184));
    tick(1);
    chk("yield_dren_dropped", {69'd0, dREN}, 70'd0);
    chk("yield_daddr_snoop", 70'(daddr), 70'h700);
    tick(4);
    wait_n = 2;
    ccwait = 1'b0;
    ccinv = 1'b0;
    wait_done(cyc);
    tick(3);
    // reset mid-writeback abandons it with no req_done
    wait_n = 100;
    req_valid = 1'b1;
    req_type = 2'd1;
    req_addr = 32'h800;
    tick(3);
    nRST = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midreset_outs", {dREN, dWEN, ccwrite, cctrans, req_done, snp_set, snp_newstate, daddr, dstore}, '0);
    @(negedge CLK);
    nRST = 1'b1;
    tick(6);
    chk("queue_drained", 70'(exp_q.size()), 70'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
